// File: rtl/gpp_apb_arbiter.sv
// Two-requester APB master for the GPP register-file slave.
// Round-robin arbitration, SETUP/ACCESS sequencing, a mandatory PSEL-low
// gap after every transfer, and a wait-state timeout that aborts with err=1.
module gpp_apb_arbiter #(
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter int unsigned TIMEOUT        = 16
) (
   input  logic                      HCLK_i,
   input  logic                      HRESET_i,
   // requester side
   input  logic [1:0]                req_i,
   input  logic [APB_ADDR_WIDTH-1:0] req0_addr_i,
   input  logic [APB_ADDR_WIDTH-1:0] req1_addr_i,
   input  logic [31:0]               req0_wdata_i,
   input  logic [31:0]               req1_wdata_i,
   input  logic                      req0_write_i,
   input  logic                      req1_write_i,
   output logic [1:0]                done_o,
   output logic [31:0]               rdata_o,
   output logic                      err_o,
   output logic                      busy_o,
   // APB master side
   output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
   output logic [31:0]               PWDATA_o,
   output logic                      PWRITE_o,
   output logic                      PSEL_o,
   output logic                      PENABLE_o,
   input  logic [31:0]               PRDATA_i,
   input  logic                      PREADY_i,
   input  logic                      PSLVERR_i
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e                    state_q, state_d;
   logic                      grant_q, grant_d;
   logic                      last_q, last_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [31:0]               pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic                      pick;
   logic                      timeout_hit;

   // On a tie the requester not granted last time wins; otherwise the lone requester.
   assign pick = (req_i == 2'b11) ? ~last_q : req_i[1];

   // Counter holds the number of stalled ACCESS cycles already seen.
   assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

   // Next-state, grant capture and response capture.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pwrite_d = pwrite_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      unique case (state_q)
         StIdle: begin
            if (|req_i) begin
               state_d = StSetup;
               grant_d = pick;
               last_d  = pick;
               if (pick) begin
                  paddr_d  = req1_addr_i;
                  pwdata_d = req1_wdata_i;
                  pwrite_d = req1_write_i;
               end else begin
                  paddr_d  = req0_addr_i;
                  pwdata_d = req0_wdata_i;
                  pwrite_d = req0_write_i;
               end
            end
         end
         StSetup: begin
            state_d = StAccess;
            cnt_d   = '0;
         end
         StAccess: begin
            if (PREADY_i) begin
               state_d = StResp;
               err_d   = PSLVERR_i;
               if (!pwrite_q) begin
                  rdata_d = PRDATA_i;
               end
            end else if (timeout_hit) begin
               state_d = StResp;
               err_d   = 1'b1;
               if (!pwrite_q) begin
                  rdata_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; synchronous reset favours requester 0 next.
   always_ff @(posedge HCLK_i) begin
      if (HRESET_i) begin
         state_q  <= StIdle;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pwrite_q <= pwrite_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Outputs decode registered state only, so no input reaches an output combinationally.
   always_comb begin
      PSEL_o    = (state_q == StSetup) || (state_q == StAccess);
      PENABLE_o = (state_q == StAccess);
      busy_o    = (state_q != StIdle);
      done_o    = 2'b00;
      if (state_q == StResp) begin
         done_o = grant_q ? 2'b10 : 2'b01;
      end
      PADDR_o   = paddr_q;
      PWDATA_o  = pwdata_q;
      PWRITE_o  = pwrite_q;
      rdata_o   = rdata_q;
      err_o     = err_q;
   end

endmodule

// File: tb/tb_gpp_apb_arbiter.sv
// Directed bench for gpp_apb_arbiter with a small behavioural APB slave.
module tb_gpp_apb_arbiter;

   localparam int unsigned AW = 12;
   localparam int unsigned TO = 16;

   logic          HCLK_i = 1'b0;
   logic          HRESET_i;
   logic [1:0]    req_i;
   logic [AW-1:0] req0_addr_i, req1_addr_i;
   logic [31:0]   req0_wdata_i, req1_wdata_i;
   logic          req0_write_i, req1_write_i;
   logic [1:0]    done_o;
   logic [31:0]   rdata_o;
   logic          err_o, busy_o;
   logic [AW-1:0] PADDR_o;
   logic [31:0]   PWDATA_o;
   logic          PWRITE_o, PSEL_o, PENABLE_o;
   logic [31:0]   PRDATA_i;
   logic          PREADY_i, PSLVERR_i;

   int n_cmp = 0;
   int n_mis = 0;

   // slave model controls
   logic [7:0]  ready_delay = 8'd0;
   logic        stuck = 1'b0;
   logic        slverr = 1'b0;
   logic [7:0]  acc_cnt = 8'd0;
   logic [31:0] mem [16];

   gpp_apb_arbiter #(.APB_ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .HCLK_i       (HCLK_i),
      .HRESET_i     (HRESET_i),
      .req_i        (req_i),
      .req0_addr_i  (req0_addr_i),
      .req1_addr_i  (req1_addr_i),
      .req0_wdata_i (req0_wdata_i),
      .req1_wdata_i (req1_wdata_i),
      .req0_write_i (req0_write_i),
      .req1_write_i (req1_write_i),
      .done_o       (done_o),
      .rdata_o      (rdata_o),
      .err_o        (err_o),
      .busy_o       (busy_o),
      .PADDR_o      (PADDR_o),
      .PWDATA_o     (PWDATA_o),
      .PWRITE_o     (PWRITE_o),
      .PSEL_o       (PSEL_o),
      .PENABLE_o    (PENABLE_o),
      .PRDATA_i     (PRDATA_i),
      .PREADY_i     (PREADY_i),
      .PSLVERR_i    (PSLVERR_i)
   );

   always #5 HCLK_i = ~HCLK_i;

   // Slave: PREADY after ready_delay stalled ACCESS cycles, never when stuck.
   assign PREADY_i  = PSEL_o && PENABLE_o && !stuck && (acc_cnt >= ready_delay);
   assign PSLVERR_i = slverr && PREADY_i;
   assign PRDATA_i  = mem[PADDR_o[5:2]];

   always @(posedge HCLK_i) begin
      if (PSEL_o && PENABLE_o && !PREADY_i) acc_cnt <= acc_cnt + 8'd1;
      else acc_cnt <= 8'd0;
      if (PSEL_o && PENABLE_o && PREADY_i && PWRITE_o) mem[PADDR_o[5:2]] <= PWDATA_o;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input int r, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic w);
      if (r == 0) begin
         req0_addr_i = a; req0_wdata_i = d; req0_write_i = w; req_i[0] = 1'b1;
      end else begin
         req1_addr_i = a; req1_wdata_i = d; req1_write_i = w; req_i[1] = 1'b1;
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
   task automatic xfer(input string tag, input int r, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic w, input int exp_lat);
      int  n = 0;
      bit  got = 0;
      drive_req(r, a, d, w);
      while (n < 40 && !got) begin
         @(negedge HCLK_i);
         n++;
         if (done_o != 2'b00) begin
            got = 1;
         end else if (n == 1) begin
            check_eq({tag, " setup psel"}, 32'(PSEL_o), 32'd1);
            check_eq({tag, " setup penable"}, 32'(PENABLE_o), 32'd0);
            check_eq({tag, " setup paddr"}, 32'(PADDR_o), 32'(a));
            // inputs may change after the grant edge without effect
            if (r == 0) begin
               req0_addr_i = ~a; req0_wdata_i = ~d; req0_write_i = ~w;
            end else begin
               req1_addr_i = ~a; req1_wdata_i = ~d; req1_write_i = ~w;
            end
         end else begin
            check_eq({tag, " access psel"}, 32'(PSEL_o), 32'd1);
            check_eq({tag, " access penable"}, 32'(PENABLE_o), 32'd1);
            check_eq({tag, " access paddr"}, 32'(PADDR_o), 32'(a));
            check_eq({tag, " access pwrite"}, 32'(PWRITE_o), 32'(w));
            if (w) check_eq({tag, " access pwdata"}, PWDATA_o, d);
         end
      end
      req_i[r] = 1'b0;
      check_eq({tag, " latency"}, 32'(n), 32'(exp_lat));
      check_eq({tag, " done"}, 32'(done_o), (r == 0) ? 32'd1 : 32'd2);
      check_eq({tag, " resp psel"}, 32'(PSEL_o), 32'd0);
      @(negedge HCLK_i);
      check_eq({tag, " idle busy"}, 32'(busy_o), 32'd0);
   endtask

   task automatic do_reset();
      HRESET_i = 1'b1;
      repeat (2) @(negedge HCLK_i);
      HRESET_i = 1'b0;
   endtask

   // Wait for a done pulse within a cycle budget; returns cycles waited (budget+1 on expiry).
   task automatic wait_done(input string tag, input int budget, output int n);
      n = 0;
      do begin
         @(negedge HCLK_i);
         n++;
      end while (done_o == 2'b00 && n <= budget);
      if (done_o == 2'b00) check_eq({tag, " timeout waiting done"}, 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      HRESET_i = 1'b1;
      req_i = 2'b00;
      req0_addr_i = '0; req1_addr_i = '0;
      req0_wdata_i = '0; req1_wdata_i = '0;
      req0_write_i = 1'b0; req1_write_i = 1'b0;
      repeat (2) @(negedge HCLK_i);
      check_eq("rst psel", 32'(PSEL_o), 32'd0);
      check_eq("rst penable", 32'(PENABLE_o), 32'd0);
      check_eq("rst paddr", 32'(PADDR_o), 32'd0);
      check_eq("rst pwdata", PWDATA_o, 32'd0);
      check_eq("rst pwrite", 32'(PWRITE_o), 32'd0);
      check_eq("rst done", 32'(done_o), 32'd0);
      check_eq("rst rdata", rdata_o, 32'd0);
      check_eq("rst err", 32'(err_o), 32'd0);
      check_eq("rst busy", 32'(busy_o), 32'd0);
      HRESET_i = 1'b0;

      // single write then read
      xfer("wr008", 0, 12'h008, 32'hDEADBEEF, 1'b1, 3);
      check_eq("wr008 rdata", rdata_o, 32'd0);
      check_eq("wr008 err", 32'(err_o), 32'd0);
      xfer("rd008", 0, 12'h008, 32'h0, 1'b0, 3);
      check_eq("rd008 rdata", rdata_o, 32'hDEADBEEF);
      check_eq("rd008 err", 32'(err_o), 32'd0);

      // simultaneous requests after reset: requester 0 first
      do_reset();
      drive_req(0, 12'h004, 32'h11, 1'b1);
      drive_req(1, 12'h00C, 32'h22, 1'b1);
      wait_done("sim0", 10, n);
      check_eq("sim first done", 32'(done_o), 32'd1);
      check_eq("sim first latency", 32'(n), 32'd3);
      req_i[0] = 1'b0;
      wait_done("sim1", 10, n);
      check_eq("sim second done", 32'(done_o), 32'd2);
      check_eq("sim second latency", 32'(n), 32'd4);
      req_i[1] = 1'b0;
      @(negedge HCLK_i);
      xfer("rd004", 0, 12'h004, 32'h0, 1'b0, 3);
      check_eq("rd004 rdata", rdata_o, 32'h11);
      xfer("rd00C", 1, 12'h00C, 32'h0, 1'b0, 3);
      check_eq("rd00C rdata", rdata_o, 32'h22);

      // continuous contention: alternate grants, 4-cycle period
      do_reset();
      drive_req(0, 12'h020, 32'hA0, 1'b1);
      drive_req(1, 12'h024, 32'hB1, 1'b1);
      for (int k = 0; k < 8; k++) begin
         wait_done("cont", 10, n);
         check_eq($sformatf("cont done %0d", k), 32'(done_o), (k % 2 == 0) ? 32'd1 : 32'd2);
         check_eq($sformatf("cont period %0d", k), 32'(n), (k == 0) ? 32'd3 : 32'd4);
         if (k == 7) req_i = 2'b00;
      end
      @(negedge HCLK_i);

      // wait states
      xfer("wr010", 1, 12'h010, 32'h5A5A5A5A, 1'b1, 3);
      ready_delay = 8'd3;
      xfer("rd010 wait", 0, 12'h010, 32'h0, 1'b0, 6);
      check_eq("rd010 rdata", rdata_o, 32'h5A5A5A5A);
      check_eq("rd010 err", 32'(err_o), 32'd0);
      ready_delay = 8'd0;

      // slave error with PREADY
      slverr = 1'b1;
      xfer("rd008 slverr", 0, 12'h008, 32'h0, 1'b0, 3);
      check_eq("slverr err", 32'(err_o), 32'd1);
      check_eq("slverr rdata", rdata_o, 32'hDEADBEEF);
      slverr = 1'b0;

      // timeouts: write keeps rdata, read zeroes it
      stuck = 1'b1;
      xfer("wr timeout", 1, 12'h030, 32'h77, 1'b1, 2 + TO);
      check_eq("wr timeout err", 32'(err_o), 32'd1);
      check_eq("wr timeout rdata", rdata_o, 32'hDEADBEEF);
      xfer("rd timeout", 0, 12'h010, 32'h0, 1'b0, 2 + TO);
      check_eq("rd timeout err", 32'(err_o), 32'd1);
      check_eq("rd timeout rdata", rdata_o, 32'd0);
      stuck = 1'b0;
      xfer("rd010 again", 1, 12'h010, 32'h0, 1'b0, 3);
      check_eq("rd010 again err", 32'(err_o), 32'd0);
      check_eq("rd010 again rdata", rdata_o, 32'h5A5A5A5A);

      // reset mid-ACCESS after requester 0 was granted
      stuck = 1'b1;
      drive_req(0, 12'h008, 32'h0, 1'b0);
      repeat (2) @(negedge HCLK_i);
      check_eq("mid penable", 32'(PENABLE_o), 32'd1);
      HRESET_i = 1'b1;
      req_i = 2'b11;
      req1_addr_i = 12'h00C; req1_write_i = 1'b0;
      @(negedge HCLK_i);
      check_eq("mid rst psel", 32'(PSEL_o), 32'd0);
      check_eq("mid rst penable", 32'(PENABLE_o), 32'd0);
      check_eq("mid rst done", 32'(done_o), 32'd0);
      check_eq("mid rst busy", 32'(busy_o), 32'd0);
      check_eq("mid rst rdata", rdata_o, 32'd0);
      HRESET_i = 1'b0;
      stuck = 1'b0;
      wait_done("post rst", 10, n);
      check_eq("post rst grant", 32'(done_o), 32'd1);
      check_eq("post rst latency", 32'(n), 32'd3);
      req_i = 2'b00;
      @(negedge HCLK_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/gpp_apb_arbiter.md
# gpp_apb_arbiter

Two-requester APB master that shares the GPP register-file APB slave between two clients, for example the core-side bridge (requester 0) and the debug/testbench port (requester 1). It arbitrates round-robin, sequences each transfer through APB SETUP and ACCESS, inserts the idle cycle the GPP slave needs between transfers, and aborts transfers that stall with an error response. It sits between the requesters and the slave's PSEL/PENABLE/PREADY pins.

## Interface
- APB_ADDR_WIDTH, 12, APB address width (matches the slave's 4 KB window).
- TIMEOUT, 16, max ACCESS cycles waited for PREADY before abort (legal range 1..255).
- HCLK  in  1  clock.
- HRESET  in  1  reset; one clock, reset is synchronous and active-high.
- req  in  2  per-requester transfer request, level, bit i = requester i.
- req0_addr, req1_addr  in  APB_ADDR_WIDTH  transfer address.
- req0_wdata, req1_wdata  in  32  write data.
- req0_write, req1_write  in  1  1 = write, 0 = read.
- done  out  2  one-cycle pulse on bit i when requester i's transfer completes.
- rdata  out  32  read data of last completed transfer, shared by both requesters.
- err  out  1  error flag of last completed transfer, valid with done.
- busy  out  1  high in any state except IDLE.
- PADDR  out  APB_ADDR_WIDTH; PWDATA  out  32; PWRITE  out  1; PSEL  out  1; PENABLE  out  1.
- PRDATA  in  32; PREADY  in  1; PSLVERR  in  1.

## Operation
- FSM states and transitions:
  - IDLE: if any req bit is set, the arbiter grants one requester and goes to SETUP.
  - SETUP: always goes to ACCESS.
  - ACCESS: goes to RESP on PREADY or on timeout; otherwise stays.
  - RESP: always goes to IDLE.
- Arbitration is evaluated only in IDLE:
  - If only one req bit is high, that requester is granted.
  - If both are high, the requester not granted last time wins.
  - The last-grant pointer resets to "1", so requester 0 wins the first tie.
- On grant, the granted requester's addr, wdata and write are registered onto PADDR, PWDATA and PWRITE. They are held stable through SETUP and ACCESS. Requester inputs may change after the grant edge without effect.
- SETUP: PSEL=1, PENABLE=0.
- ACCESS: PSEL=1, PENABLE=1. A wait-cycle counter clears on entry and increments each ACCESS cycle without PREADY.
- ACCESS with PREADY=1:
  - Read: capture PRDATA into rdata.
  - Write: leave rdata unchanged.
  - Capture err = PSLVERR.
- Timeout: if the counter reaches TIMEOUT with PREADY still low, go to RESP with err=1. A read timeout loads rdata=0; a write timeout leaves rdata unchanged.
- RESP: PSEL=0, PENABLE=0, done[grant]=1 for exactly this cycle. This cycle also serves as the mandatory PSEL-low gap. The GPP slave ignores a SETUP that immediately follows an ACCESS, so transfers are never issued back-to-back.
- Requester contract: the requester drops req on the edge where it sees done high, so req is low in the following IDLE cycle. A req still high in that IDLE cycle is treated as a new transfer.
- rdata and err hold their values until the next RESP.
- A req bit raised during SETUP, ACCESS or RESP is ignored until IDLE.
- Reset asserted mid-transfer:
  - The next state is IDLE and all outputs take their reset values.
  - No done pulse is produced for the aborted transfer.
  - The pointer returns to favour requester 0.

## Timing
- Reset values: PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, done=00, rdata=0, err=0, busy=0, state IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Zero-wait transfer: req high in IDLE cycle t → SETUP t+1 → ACCESS t+2 (PREADY sampled high) → RESP with done at t+3 → IDLE t+4.
- Minimum period is 4 cycles per transfer; each wait state adds 1 cycle.
- Timeout: RESP occurs at cycle t+2+TIMEOUT when PREADY never rises.
- Two requesters held continuously are served alternately, 4 cycles each, with no starvation.

## Test plan
- Single write then read: req0 write addr 0x008 data 0xDEADBEEF, then read 0x008.
  - Each done[0] pulse comes 3 cycles after the IDLE request cycle.
  - The write leaves rdata and err=0 unchanged; the read returns rdata=0xDEADBEEF, err=0.
  - PSEL is low in the cycle after each ACCESS.
- Simultaneous requests after reset: both req high, req0 writes 0x004←0x11, req1 writes 0x00C←0x22.
  - Requester 0 is served first, then requester 1 starting on the next IDLE.
  - A later read-back returns 0x11 and 0x22.
- Continuous contention: both req held for 8 transfers → grants alternate 0,1,0,1…; done bits never overlap; each period is 4 cycles.
- Wait states: slave model delays PREADY by 3 ACCESS cycles on a read of 0x010 holding 0x5A5A5A5A.
  - PSEL and PENABLE stay high and PADDR stays stable throughout.
  - done comes at t+6 with rdata=0x5A5A5A5A.
- Timeout and error:
  - PREADY tied low, read: done at t+2+TIMEOUT with err=1, rdata=0.
  - PSLVERR=1 with PREADY: err=1 on that done.
- Reset mid-ACCESS: HRESET asserted during ACCESS → next cycle PSEL=0, PENABLE=0, no done pulse; after release a pending req1 and req0 tie is granted to requester 0.
